// File: rtl/point_loader.sv
// point_loader: input-side writer for the point LUT register file.
//   Collects scalar M, then x, then y as NUM_WORDS stream words each (MSB word first),
//   issues a one-cycle X/Y LUT write, and holds M for the scalar-multiplication controller.
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   i_in_valid/i_in_data       input word stream; o_in_ready is registered
//   X_in_data/Y_in_data        assembled x/y to the LUT write ports, X_we/Y_we 1-cycle pulse
//   o_scalar/o_scalar_valid    assembled M, valid from COMMIT until i_ack
//   o_range_err                x>=p or y>=p (p = 2^255-19), meaningful with o_scalar_valid
//   i_ack                      controller finished with the point; re-arms the loader in HOLD
module point_loader #(
  parameter int WORD_W    = 64,
  parameter int NUM_WORDS = 4,
  parameter int FIELD_W   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  input  logic [WORD_W-1:0]  i_in_data,
  output logic               o_in_ready,
  output logic [FIELD_W-1:0] X_in_data,
  output logic [FIELD_W-1:0] Y_in_data,
  output logic               X_we,
  output logic               Y_we,
  output logic [FIELD_W-1:0] o_scalar,
  output logic               o_scalar_valid,
  output logic               o_range_err,
  input  logic               i_ack
);

  localparam int SH_W  = WORD_W * NUM_WORDS;
  localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    LOAD_M = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    COMMIT = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [FIELD_W-1:0] m_q, m_d;
  logic [FIELD_W-1:0] x_q, x_d;
  logic               ready_q, ready_d;
  logic [FIELD_W-1:0] x_out_q, x_out_d;
  logic [FIELD_W-1:0] y_out_q, y_out_d;
  logic [FIELD_W-1:0] scalar_q, scalar_d;
  logic               we_q, we_d;
  logic               scalar_valid_q, scalar_valid_d;
  logic               range_err_q, range_err_d;

  logic               accept;
  logic               field_done;
  logic [SH_W-1:0]    sh_shift;
  logic [FIELD_W-1:0] field;
  logic               unused_msb;

  // Field >= 2^255-19: bits [254:5] all ones and the low five bits at or
  // above p's low five bits (0x0D).
  function automatic logic ge_p(input logic [FIELD_W-1:0] f);
    return (&f[FIELD_W-1:5]) && (f[4:0] >= 5'h0D);
  endfunction

  assign accept     = i_in_valid && ready_q;
  assign field_done = accept && (cnt_q == CNT_LAST);
  assign sh_shift   = {sh_q[SH_W-WORD_W-1:0], i_in_data};
  // The top assembled bit is dropped without flagging anything.
  assign field      = sh_shift[FIELD_W-1:0];
  assign unused_msb = sh_shift[SH_W-1];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sh_d           = sh_q;
    m_d            = m_q;
    x_d            = x_q;
    ready_d        = ready_q;
    x_out_d        = x_out_q;
    y_out_d        = y_out_q;
    scalar_d       = scalar_q;
    we_d           = 1'b0;
    scalar_valid_d = scalar_valid_q;
    range_err_d    = range_err_q;

    if (accept) begin
      sh_d  = sh_shift;
      cnt_d = cnt_q + 1'b1;  // wraps to 0 on field completion
    end

    unique case (state_q)
      LOAD_M: begin
        ready_d = 1'b1;
        if (field_done) begin
          m_d     = field;
          state_d = LOAD_X;
        end
      end
      LOAD_X: begin
        ready_d = 1'b1;
        if (field_done) begin
          x_d     = field;
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        ready_d = 1'b1;
        if (field_done) begin
          // Outputs are registered, so everything the COMMIT cycle shows is
          // loaded on the edge that accepts the last y word.
          ready_d        = 1'b0;
          state_d        = COMMIT;
          x_out_d        = x_q;
          y_out_d        = field;
          scalar_d       = m_q;
          we_d           = 1'b1;
          scalar_valid_d = 1'b1;
          range_err_d    = ge_p(x_q) || ge_p(field);
        end
      end
      COMMIT: begin
        // i_ack is deliberately not looked at here.
        ready_d = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        ready_d = 1'b0;
        if (i_ack) begin
          state_d        = LOAD_M;
          cnt_d          = '0;
          scalar_valid_d = 1'b0;
          ready_d        = 1'b1;
        end
      end
      default: begin
        state_d = LOAD_M;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD_M;
      cnt_q          <= '0;
      sh_q           <= '0;
      m_q            <= '0;
      x_q            <= '0;
      ready_q        <= 1'b0;
      x_out_q        <= '0;
      y_out_q        <= '0;
      scalar_q       <= '0;
      we_q           <= 1'b0;
      scalar_valid_q <= 1'b0;
      range_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sh_q           <= sh_d;
      m_q            <= m_d;
      x_q            <= x_d;
      ready_q        <= ready_d;
      x_out_q        <= x_out_d;
      y_out_q        <= y_out_d;
      scalar_q       <= scalar_d;
      we_q           <= we_d;
      scalar_valid_q <= scalar_valid_d;
      range_err_q    <= range_err_d;
    end
  end

  assign o_in_ready     = ready_q;
  assign X_in_data      = x_out_q;
  assign Y_in_data      = y_out_q;
  assign X_we           = we_q;
  assign Y_we           = we_q;
  assign o_scalar       = scalar_q;
  assign o_scalar_valid = scalar_valid_q;
  assign o_range_err    = range_err_q;

endmodule

// File: tb/tb_point_loader.sv
// Directed bench for point_loader: a table of point loads with hand-computed
// expected LUT/scalar outputs, plus sequences for reset, HOLD backpressure,
// i_ack during COMMIT and reset in the middle of a load.
module tb_point_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_in_valid;
  logic [63:0]  i_in_data;
  logic         o_in_ready;
  logic [254:0] X_in_data;
  logic [254:0] Y_in_data;
  logic         X_we;
  logic         Y_we;
  logic [254:0] o_scalar;
  logic         o_scalar_valid;
  logic         o_range_err;
  logic         i_ack;

  int tests  = 0;
  int errors = 0;

  point_loader dut (
    .clk            (clk),
    .rst            (rst),
    .i_in_valid     (i_in_valid),
    .i_in_data      (i_in_data),
    .o_in_ready     (o_in_ready),
    .X_in_data      (X_in_data),
    .Y_in_data      (Y_in_data),
    .X_we           (X_we),
    .Y_we           (Y_we),
    .o_scalar       (o_scalar),
    .o_scalar_valid (o_scalar_valid),
    .o_range_err    (o_range_err),
    .i_ack          (i_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] m;
    logic [255:0] x;
    logic [255:0] y;
    logic         gaps;       // randomly deassert i_in_valid
    logic         hold_poke;  // drive valid for 20 cycles in HOLD before i_ack
    logic         ack_commit; // pulse i_ack during the COMMIT cycle
    logic [255:0] ex_m;
    logic [255:0] ex_x;
    logic [255:0] ex_y;
    logic         ex_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [255:0] m, x, y, input logic gaps, hp, ac,
                              input logic [255:0] em, ex, ey, input logic err);
    vec_t v;
    v.m = m; v.x = x; v.y = y;
    v.gaps = gaps; v.hold_poke = hp; v.ack_commit = ac;
    v.ex_m = em; v.ex_x = ex; v.ex_y = ey; v.ex_err = err;
    return v;
  endfunction

  function automatic logic [63:0] word_of(input vec_t v, input int idx);
    logic [255:0] f;
    int base;
    f = (idx < 4) ? v.m : (idx < 8) ? v.x : v.y;
    base = 255 - 64 * (idx % 4);
    return f[base -: 64];
  endfunction

  // Drives one full point, checks COMMIT and HOLD, then re-arms with i_ack.
  task automatic load_point(input vec_t v, input string tag);
    int  idx = 0;
    int  cycles = 0;
    logic rdy, vld, early_we, bad_hold;
    early_we = 1'b0;
    while (idx < 12 && cycles < 500) begin
      @(negedge clk);
      if (X_we || Y_we) early_we = 1'b1;
      rdy = o_in_ready;
      vld = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_in_valid = vld;
      i_in_data  = vld ? word_of(v, idx) : {$urandom, $urandom};
      if (vld && rdy) idx++;
      cycles++;
    end
    check({tag, " words_accepted"}, 256'(idx), 256'd12);
    check({tag, " no_early_we"}, 256'(early_we), 256'd0);
    // COMMIT cycle: one cycle after the edge that took the 12th word.
    @(negedge clk);
    i_in_valid = 1'b0;
    i_in_data  = '0;
    check({tag, " commit X_we"}, 256'(X_we), 256'd1);
    check({tag, " commit Y_we"}, 256'(Y_we), 256'd1);
    check({tag, " commit ready"}, 256'(o_in_ready), 256'd0);
    check({tag, " commit scalar_valid"}, 256'(o_scalar_valid), 256'd1);
    check({tag, " X_in_data"}, {1'b0, X_in_data}, v.ex_x);
    check({tag, " Y_in_data"}, {1'b0, Y_in_data}, v.ex_y);
    check({tag, " o_scalar"}, {1'b0, o_scalar}, v.ex_m);
    check({tag, " range_err"}, 256'(o_range_err), 256'(v.ex_err));
    if (v.ack_commit) i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    check({tag, " hold we_low"}, 256'({X_we, Y_we}), 256'd0);
    check({tag, " hold scalar_valid"}, 256'(o_scalar_valid), 256'd1);
    check({tag, " hold ready"}, 256'(o_in_ready), 256'd0);
    if (v.hold_poke) begin
      bad_hold = 1'b0;
      for (int k = 0; k < 20; k++) begin
        i_in_valid = 1'b1;
        i_in_data  = {$urandom, $urandom};
        @(negedge clk);
        if (o_in_ready || X_we || Y_we || !o_scalar_valid) bad_hold = 1'b1;
      end
      i_in_valid = 1'b0;
      check({tag, " hold_poke stable"}, 256'(bad_hold), 256'd0);
      check({tag, " hold_poke X held"}, {1'b0, X_in_data}, v.ex_x);
    end
    i_ack = 1'b1;
    @(negedge clk);
    i_ack = 1'b0;
    check({tag, " ack ready"}, 256'(o_in_ready), 256'd1);
    check({tag, " ack scalar_valid"}, 256'(o_scalar_valid), 256'd0);
    check({tag, " ack scalar held"}, {1'b0, o_scalar}, v.ex_m);
    check({tag, " ack Y held"}, {1'b0, Y_in_data}, v.ex_y);
  endtask

  localparam logic [255:0] Y0  = 256'h20AE19A1_B8A086B4_E01EDD2C_7748D14C_923D4D7E_6D7C61B2_29E9C5A2_7ECED358;
  localparam logic [255:0] TOP = 256'hFFFFFFFF_FFFFFFFF_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] TOP_EX = 256'h7FFFFFFF_FFFFFFFF_00000000_00000000_00000000_00000000_00000000_00000000;
  localparam logic [255:0] P19 = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
  localparam logic [255:0] P20 = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFEC;
  localparam logic [255:0] P19_HI = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
  localparam logic [255:0] M_HI = 256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000003;

  initial begin
    logic bad;
    vecs[0] = mk(256'd1, 256'd9, Y0, 1'b0, 1'b1, 1'b0, 256'd1, 256'd9, Y0, 1'b0);
    vecs[1] = mk(256'd1, 256'd9, Y0, 1'b1, 1'b0, 1'b0, 256'd1, 256'd9, Y0, 1'b0);
    vecs[2] = mk(M_HI, TOP, 256'd5, 1'b0, 1'b0, 1'b1, 256'd3, TOP_EX, 256'd5, 1'b0);
    vecs[3] = mk(256'd2, P19, 256'd0, 1'b0, 1'b0, 1'b0, 256'd2, P19, 256'd0, 1'b1);
    vecs[4] = mk(256'd2, P20, 256'd0, 1'b0, 1'b0, 1'b0, 256'd2, P20, 256'd0, 1'b0);
    vecs[5] = mk(256'd7, 256'd1, P19_HI, 1'b0, 1'b0, 1'b0, 256'd7, 256'd1, P19, 1'b1);
    vecs[6] = mk(256'd8, P20, P20, 1'b1, 1'b0, 1'b0, 256'd8, P20, P20, 1'b0);

    rst = 1'b1;
    i_in_valid = 1'b0;
    i_in_data = '0;
    i_ack = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset ready", 256'(o_in_ready), 256'd0);
    check("reset we", 256'({X_we, Y_we}), 256'd0);
    check("reset scalar_valid", 256'(o_scalar_valid), 256'd0);
    check("reset range_err", 256'(o_range_err), 256'd0);
    check("reset X_in_data", {1'b0, X_in_data}, 256'd0);
    check("reset o_scalar", {1'b0, o_scalar}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", 256'(o_in_ready), 256'd1);

    for (int i = 0; i < 7; i++) load_point(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of LOAD_X: 6 words accepted, then rst.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      i_in_valid = 1'b1;
      i_in_data  = word_of(vecs[3], k);
    end
    @(negedge clk);
    i_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset ready", 256'(o_in_ready), 256'd0);
    check("midreset we", 256'({X_we, Y_we}), 256'd0);
    check("midreset X_in_data", {1'b0, X_in_data}, 256'd0);
    check("midreset Y_in_data", {1'b0, Y_in_data}, 256'd0);
    check("midreset o_scalar", {1'b0, o_scalar}, 256'd0);
    check("midreset valid/err", 256'({o_scalar_valid, o_range_err}), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (X_we || Y_we) bad = 1'b1;
    end
    check("midreset no write", 256'(bad), 256'd0);
    load_point(vecs[3], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
